// File: rtl/hwpf_pkg.sv
// Shared types and helpers for the hardware prefetcher request path.
package hwpf_pkg;

  localparam int ADDR_WIDTH       = 40;
  localparam int TID_WIDTH        = 7;
  localparam int LINE_BYTES       = 64;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

  // One queued prefetch: a cache-line address plus its transaction id.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [TID_WIDTH-1:0]  tid;
  } hwpf_entry_t;

  // Clear the line-offset bits so every queued address names a whole line.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~(ADDR_WIDTH'(LINE_BYTES - 1));
  endfunction

endpackage

// File: rtl/hwpf_req_queue_if.sv
// Insert, cancel and issue signals between the prefetch address generator,
// the demand path and the dcache request arbiter.
interface hwpf_req_queue_if #(
  parameter int INSERTS     = 2,
  parameter int QUEUE_DEPTH = 8
);

  logic                                          flush_i;
  logic                                          lock_i;
  logic [INSERTS-1:0]                            insert_valid_i;
  logic [INSERTS-1:0][hwpf_pkg::ADDR_WIDTH-1:0]  insert_addr_i;
  logic [INSERTS-1:0][hwpf_pkg::TID_WIDTH-1:0]   insert_tid_i;
  logic [INSERTS-1:0]                            cancel_valid_i;
  logic [INSERTS-1:0][hwpf_pkg::TID_WIDTH-1:0]   cancel_tid_i;
  logic [INSERTS-1:0]                            cancel_hit_o;
  logic                                          req_valid_o;
  logic [hwpf_pkg::ADDR_WIDTH-1:0]               req_addr_o;
  logic [hwpf_pkg::TID_WIDTH-1:0]                req_tid_o;
  logic                                          req_ready_i;
  logic [$clog2(QUEUE_DEPTH):0]                  count_o;
  logic                                          full_o;
  logic [$clog2(INSERTS):0]                      drop_o;

  // The queue itself.
  modport slave (
    input  flush_i, lock_i, insert_valid_i, insert_addr_i, insert_tid_i,
           cancel_valid_i, cancel_tid_i, req_ready_i,
    output cancel_hit_o, req_valid_o, req_addr_o, req_tid_o,
           count_o, full_o, drop_o
  );

  // Whoever drives the queue (generator, demand path and arbiter together).
  modport master (
    output flush_i, lock_i, insert_valid_i, insert_addr_i, insert_tid_i,
           cancel_valid_i, cancel_tid_i, req_ready_i,
    input  cancel_hit_o, req_valid_o, req_addr_o, req_tid_o,
           count_o, full_o, drop_o
  );

endinterface

// File: rtl/hwpf_compact.sv
// Stable compaction: entries whose keep bit is set move toward index 0 in
// their original order; freed slots at the top read as all-zero.
module hwpf_compact
  import hwpf_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  hwpf_entry_t [DEPTH-1:0] entries_in,
  input  logic        [DEPTH-1:0] keep,
  output hwpf_entry_t [DEPTH-1:0] entries_out,
  output logic        [CW-1:0]    kept
);

  // Running prefix count of kept entries gives each survivor its new slot.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    entries_out = '0;
    kept        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        entries_out[kept[CW-2:0]] = entries_in[i];
        kept                      = kept + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hwpf_req_queue.sv
// Age-ordered prefetch request queue: deduplicating multi-port insert,
// tid-based cancel, and oldest-first issue over valid/ready.
module hwpf_req_queue
  import hwpf_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter int INSERTS     = 2,
  parameter int DEDUP_EN    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  hwpf_req_queue_if.slave         bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int IW = $clog2(QUEUE_DEPTH);
  localparam int DW = $clog2(INSERTS) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  hwpf_entry_t [QUEUE_DEPTH-1:0] slots_q;
  hwpf_entry_t [QUEUE_DEPTH-1:0] survivors;
  hwpf_entry_t [QUEUE_DEPTH-1:0] slots_d;
  logic        [CW-1:0]          count_q;
  logic        [CW-1:0]          survived;
  logic        [CW-1:0]          count_d;
  logic        [DW-1:0]          drop_q;
  logic        [DW-1:0]          drop_d;
  logic        [QUEUE_DEPTH-1:0] cancel_match;
  logic        [QUEUE_DEPTH-1:0] keep;
  logic                          pop;
  logic                          dup;
  logic        [ADDR_WIDTH-1:0]  aligned;

  // Mark every valid slot claimed by any active cancel; report hits per port.
  always_comb begin
    cancel_match     = '0;
    bus.cancel_hit_o = '0;
    for (int i = 0; i < INSERTS; i++) begin
      for (int j = 0; j < QUEUE_DEPTH; j++) begin
        if (bus.cancel_valid_i[i] && slots_q[j].valid &&
            slots_q[j].tid == bus.cancel_tid_i[i]) begin
          cancel_match[j]     = 1'b1;
          bus.cancel_hit_o[i] = 1'b1;
        end
      end
    end
  end

  // A head being cancelled this cycle is never offered to the arbiter.
  assign bus.req_valid_o = slots_q[0].valid & ~cancel_match[0];
  assign bus.req_addr_o  = slots_q[0].line_addr;
  assign bus.req_tid_o   = slots_q[0].tid;
  assign pop             = bus.req_valid_o & bus.req_ready_i & ~bus.lock_i;

  // An entry survives unless cancelled or popped; head pop+cancel removes it once.
  always_comb begin
    for (int j = 0; j < QUEUE_DEPTH; j++) begin
      keep[j] = slots_q[j].valid & ~cancel_match[j];
    end
    keep[0] = keep[0] & ~pop;
  end

  hwpf_compact #(
    .DEPTH       (QUEUE_DEPTH)
  ) u_compact (
    .entries_in  (slots_q),
    .keep        (keep),
    .entries_out (survivors),
    .kept        (survived)
  );

  // Append accepted inserts after the survivors in port order, filtering
  // duplicates against survivors and earlier accepted ports.
  always_comb begin
    slots_d = survivors;
    count_d = survived;
    drop_d  = '0;
    dup     = 1'b0;
    aligned = '0;
    for (int p = 0; p < INSERTS; p++) begin
      dup     = 1'b0;
      aligned = line_align(bus.insert_addr_i[p]);
      if (!bus.lock_i && bus.insert_valid_i[p]) begin
        if (DEDUP_EN != 0) begin
          for (int j = 0; j < QUEUE_DEPTH; j++) begin
            if (slots_d[j].valid && slots_d[j].line_addr == aligned) dup = 1'b1;
          end
        end
        if (!dup) begin
          if (count_d < DEPTH_C) begin
            slots_d[count_d[IW-1:0]] = '{valid: 1'b1, line_addr: aligned,
                                         tid: bus.insert_tid_i[p]};
            count_d = count_d + CW'(1);
          end else begin
            drop_d = drop_d + DW'(1);
          end
        end
      end
    end
  end

  // Queue state register; flush takes priority over every other update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: slot payloads are cleared too, because slot 0 drives req_addr_o/req_tid_o directly.
    if (rst_i) begin
      slots_q <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else if (bus.flush_i) begin
      slots_q <= '0;
      count_q <= '0;
      drop_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      slots_q <= slots_d;
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.count_o = count_q;
  assign bus.full_o  = (count_q == DEPTH_C);
  assign bus.drop_o  = drop_q;

endmodule

// File: doc/hwpf_req_queue.md
Name: hwpf_req_queue

Overview:
- Age-ordered, multi-port prefetch request queue for the Sargantana hardware prefetcher.
- Sits between the prefetch address generator and the dcache request arbiter.
- Accepts up to INSERTS candidate line requests per cycle and drops duplicates of lines already queued.
- Removes entries whose TID a demand request has claimed, and issues the oldest survivor through a valid/ready handshake.

Parameters:
- QUEUE_DEPTH, 8: entry count; power of two, ≥2.
- INSERTS, 2: number of parallel insert ports and cancel ports.
- ADDR_WIDTH, 40: physical address width.
- TID_WIDTH, 7: transaction id width.
- LINE_BYTES, 64: cache line size; power of two; sets the line-offset bits cleared on insert.
- DEDUP_EN, 1: 1 enables line-address deduplication on insert.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of all entries.
- lock_i  in  1  freezes pop and insert.
- insert_valid_i  in  [INSERTS]  candidate valid per port.
- insert_addr_i  in  [INSERTS]xADDR_WIDTH  candidate address.
- insert_tid_i  in  [INSERTS]xTID_WIDTH  candidate tid.
- cancel_valid_i  in  [INSERTS]  demand-claim valid per port.
- cancel_tid_i  in  [INSERTS]xTID_WIDTH  tid to remove.
- cancel_hit_o  out  [INSERTS]  combinational; port i matched ≥1 valid entry.
- req_valid_o  out  1  head request valid.
- req_addr_o  out  ADDR_WIDTH  head line address.
- req_tid_o  out  TID_WIDTH  head tid.
- req_ready_i  in  1  arbiter accepts head.
- count_o  out  $clog2(QUEUE_DEPTH)+1  valid entries (registered).
- full_o  out  1  count_o == QUEUE_DEPTH.
- drop_o  out  $clog2(INSERTS)+1  inserts dropped this cycle (overflow only; duplicates are not counted).

Behaviour:
- Storage:
  - Compacting shift array; slot 0 is oldest.
  - Valid slots are always contiguous from 0, so count_o is the first empty slot index.
- Reset (rst_i=1, asynchronous) and flush_i (synchronous):
  - Clear all valid bits and count.
  - Outputs go to: req_valid_o=0, req_addr_o=0, req_tid_o=0, count_o=0, full_o=0, drop_o=0.
  - cancel_hit_o=0 while the queue is empty.
- Priority: flush_i overrides lock, pop, cancel and insert in the same cycle.
- Head output:
  - req_valid_o = slot0.valid AND NOT (slot0.tid matches any active cancel_tid_i).
  - req_addr_o and req_tid_o come from slot 0.
- Pop:
  - Occurs when req_valid_o & req_ready_i & !lock_i.
  - Slot 0 is removed at the clock edge.
- Cancel:
  - Every valid entry whose tid equals any active cancel_tid_i is removed at the edge.
  - Multiple matches are all removed.
  - Cancels apply even under lock_i (correctness over throughput).
  - cancel_hit_o[i] = cancel_valid_i[i] & (any valid entry tid == cancel_tid_i[i]).
  - Inserts in the same cycle are not searched.
- Insert, when !lock_i. Each port is processed in ascending port order after removals:
  - Address is line-aligned (low $clog2(LINE_BYTES) bits forced to 0).
  - If DEDUP_EN: drop silently when the aligned address equals a surviving entry or an accepted lower-index insert of this cycle. Duplicate drops are not counted in drop_o.
  - Otherwise append at the next free slot if space remains. Space counts slots freed by this cycle's pop and cancels.
  - Otherwise count the drop in drop_o.
- Next state:
  - Survivors compact toward slot 0, preserving relative age, then accepted inserts append in port order.
  - count_next = count - removed + accepted; it never exceeds QUEUE_DEPTH.
- drop_o: registered, valid the cycle after the event.
- Latency: an insert into an empty queue shows on req_valid_o the next cycle.
- Simultaneous pop and cancel of the head: removed once; count decrements by 1.
- Reset mid-operation: any handshake in flight is abandoned and no request is issued.

Decomposition:
- Shared package hwpf_pkg holds:
  - typedef hwpf_entry_t {valid, line_addr, tid}
  - function line_align()
  - localparam LINE_OFFSET_BITS
- Natural sub-module hwpf_compact: combinational keep-mask → stable prefix-sum compaction of the entry array. Reusable by other prefetchers.

Test Plan:
- Insert 0x1000/tid 3 and 0x2047/tid 5 in one cycle, req_ready_i=1 → queue issues 0x1000/3 then 0x2040/5 on consecutive cycles; count_o goes 2→1→0.
- Insert 0x1010 on port0 and 0x1030 on port1 with DEDUP_EN=1 → one entry 0x1000; drop_o=0.
- Fill 8 entries (count_o=8, full_o=1), then insert 2 with req_ready_i=1 → 1 accepted, drop_o=1, count_o stays 8.
- Queue tids [3,5,3,9]; cancel_tid 3 → cancel_hit_o[0]=1; next cycle count_o=2, head tid 5, order 5,9.
- Head tid 3 with req_ready_i=1 and cancel tid 3 in the same cycle → req_valid_o=0 that cycle; entry gone; count_o decrements by 1.
- lock_i=1 with a valid head and ready → no pop, insert ignored, cancel still removes.
- flush_i and insert together → count_o=0 next cycle.
- rst_i pulse mid-stream → all outputs 0 asynchronously.
